// File: rtl/int_ctrl_if.sv
// Configuration and interrupt handshake bundle between the controller (slave)
// and the CPU / jump-control side (master).
interface int_ctrl_if;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic [7:0] cfg_rdata;
  logic       irq_out;
  logic [7:0] irq_vec;
  logic       irq_ack;
  logic       irq_done;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
    input  cfg_rdata, irq_out, irq_vec
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, irq_ack, irq_done,
    output cfg_rdata, irq_out, irq_vec
  );
endinterface

// File: rtl/int_ctrl.sv
// Four-source prioritised interrupt controller: synchronised edge capture,
// mask/pending registers and a non-nesting request/service handshake.
//
// state   | meaning
// IDLE    | no request outstanding; picks lowest enabled pending source
// REQ     | irq_out high, waiting for irq_ack (or withdrawal)
// SERVICE | handler running; waits for irq_done, no nesting
module int_ctrl #(
  parameter logic [7:0] VEC_BASE = 8'hF0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_src,
  int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] sync1, sync2, sync3;
  logic [3:0] pending, pending_nxt;
  logic [3:0] mask, mask_nxt;
  logic [1:0] id, id_nxt;
  logic       irq_out_q, irq_out_nxt;
  logic [7:0] irq_vec_q, irq_vec_nxt;
  logic [3:0] edge_det;
  logic [3:0] sw_clr;
  logic [3:0] ack_clr;
  logic [3:0] enabled;
  logic       wr_mask, wr_pend;
  logic       unused_wdata;

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign edge_det     = sync2 & ~sync3;
  assign wr_mask      = bus.cfg_we && (bus.cfg_addr == 2'd0);
  assign wr_pend      = bus.cfg_we && (bus.cfg_addr == 2'd1);
  assign sw_clr       = wr_pend ? bus.cfg_wdata[3:0] : 4'h0;
  assign enabled      = pending & mask;
  assign unused_wdata = ^bus.cfg_wdata[7:4];

  always_comb begin
    state_nxt   = state;
    id_nxt      = id;
    irq_out_nxt = irq_out_q;
    irq_vec_nxt = irq_vec_q;
    ack_clr     = 4'h0;
    case (state)
      IDLE: begin
        if (enabled != 4'h0) begin
          id_nxt      = lowest_set(enabled);
          irq_vec_nxt = VEC_BASE + {4'b0000, lowest_set(enabled), 2'b00};
          irq_out_nxt = 1'b1;
          state_nxt   = REQ;
        end
      end
      REQ: begin
        // ack is checked first so it beats a simultaneous withdrawal
        if (bus.irq_ack) begin
          ack_clr     = 4'b0001 << id;
          irq_out_nxt = 1'b0;
          state_nxt   = SERVICE;
        end else if (!mask[id] || !pending[id]) begin
          irq_out_nxt = 1'b0;
          state_nxt   = IDLE;
        end
      end
      SERVICE: begin
        if (bus.irq_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        irq_out_nxt = 1'b0;
        state_nxt   = IDLE;
      end
    endcase
  end

  // a freshly detected edge beats both software and ack clears
  assign pending_nxt = (pending & ~sw_clr & ~ack_clr) | edge_det;
  assign mask_nxt    = wr_mask ? bus.cfg_wdata[3:0] : mask;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1     <= 4'h0;
      sync2     <= 4'h0;
      sync3     <= 4'h0;
      pending   <= 4'h0;
      mask      <= 4'h0;
      state     <= IDLE;
      id        <= 2'd0;
      irq_out_q <= 1'b0;
      irq_vec_q <= VEC_BASE;
    end else begin
      sync1     <= irq_src;
      sync2     <= sync1;
      sync3     <= sync2;
      pending   <= pending_nxt;
      mask      <= mask_nxt;
      state     <= state_nxt;
      id        <= id_nxt;
      irq_out_q <= irq_out_nxt;
      irq_vec_q <= irq_vec_nxt;
    end
  end

  always_comb begin
    bus.cfg_rdata = 8'h00;
    case (bus.cfg_addr)
      2'd0:    bus.cfg_rdata = {4'h0, mask};
      2'd1:    bus.cfg_rdata = {4'h0, pending};
      2'd2:    bus.cfg_rdata = {state, 4'h0, id};
      default: bus.cfg_rdata = 8'h00;
    endcase
  end

  assign bus.irq_out = irq_out_q;
  assign bus.irq_vec = irq_vec_q;

endmodule
